load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, alignment rule.
// Purely declarative; no timing of its own.
// No flow control here; the FSM in load_store_unit owns the handshake.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Reserved size is treated as a misaligned access so it never touches memory.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      SZ_WORD: mis = (off != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational, zero cycles.
// No flow control; outputs follow inputs in the same cycle.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Little-endian lane selection: byte lane from addr[1:0], half lane from addr[1].
  always_comb begin
    byte_lane = word_i[7:0];
    case (off_i)
      2'd0: byte_lane = word_i[7:0];
      2'd1: byte_lane = word_i[15:8];
      2'd2: byte_lane = word_i[23:16];
      2'd3: byte_lane = word_i[31:24];
      default: byte_lane = word_i[7:0];
    endcase
    half_lane = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Sign- or zero-extend the selected lane; whole words pass straight through.
  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_BYTE: load_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
      SZ_HALF: load_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
      default: load_o = word_i;
    endcase
  end

  // Drop the low store bits into the addressed lane, keep the other lanes as read.
  always_comb begin
    merge_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        case (off_i)
          2'd0: merge_o[7:0]   = wdata_i[7:0];
          2'd1: merge_o[15:8]  = wdata_i[7:0];
          2'd2: merge_o[23:16] = wdata_i[7:0];
          2'd3: merge_o[31:24] = wdata_i[7:0];
          default: merge_o = word_i;
        endcase
      end
      SZ_HALF: begin
        if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
        else          merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU load/store front end to a single-ported word memory with sub-word RMW stores.
// Loads 2 cycles, word stores 2, sub-word stores 3, misaligned 1 (accept to resp_valid).
// req_ready only in IDLE; the response pulse is not back-pressured.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic        write_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        misal_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [31:0] maddr_q;
  logic [31:0] mwdata_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_misal;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic [31:0] wr_data;
  logic [31:0] resp_now;

  // Address bits above the memory depth are deliberately dropped so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:DEPTH_LOG2+2];

  assign accept    = req_valid && (state_q == IDLE);
  assign req_misal = is_misaligned(req_size, req_addr[1:0]);

  lsu_align u_align (
    .word_i     (word_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (off_q),
    .wdata_i    (wdata_q),
    .load_o     (load_data),
    .merge_o    (merge_data)
  );

  // Word stores write the request data as-is; sub-word stores write the merged word.
  assign wr_data  = (size_q == SZ_WORD) ? wdata_q : merge_data;
  // Stores and errors report zero data; only good loads return the extracted lane.
  assign resp_now = (misal_q || write_q) ? 32'd0 : load_data;

  // State register; reset aborts any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: misaligned goes straight to RESP, sub-word stores read first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_misal)                 state_d = RESP;
          else if (!req_write)           state_d = RD;
          else if (req_size == SZ_WORD)  state_d = WR;
          else                           state_d = RD;
        end
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch on acceptance; read word capture in RD; held output values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q  <= 1'b0;
      size_q   <= SZ_BYTE;
      uns_q    <= 1'b0;
      misal_q  <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= 32'd0;
      word_q   <= 32'd0;
      maddr_q  <= 32'd0;
      mwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        misal_q <= req_misal;
        off_q   <= req_addr[1:0];
        wdata_q <= req_wdata;
        maddr_q <= {{(32-DEPTH_LOG2){1'b0}}, req_addr[DEPTH_LOG2+1:2]};
      end
      if (state_q == RD)   word_q   <= mem_rdata;
      if (state_q == WR)   mwdata_q <= wr_data;
      if (state_q == RESP) rdata_q  <= resp_now;
    end
  end

  // Outputs decode directly from state so read and write are mutually exclusive.
  always_comb begin
    req_ready       = (state_q == IDLE);
    mem_read        = (state_q == RD);
    mem_write       = (state_q == WR);
    resp_valid      = (state_q == RESP);
    resp_misaligned = (state_q == RESP) && misal_q;
    resp_rdata      = (state_q == RESP) ? resp_now : rdata_q;
    mem_wdata       = (state_q == WR) ? wr_data : mwdata_q;
    mem_addr        = maddr_q;
  end

endmodule
